alu_mc: RTL and testbench

Parametrised execution-stage ALU: the next generation of the single-cycle add/sub unit, generalised in datapath width and forwarding depth. It adds a valid/ready issue handshake, iterative multi-cycle multiply and divide, and an N-deep result-history buffer that replaces the fixed es1/es2 forwarding registers. It sits between register read and writeback in the pipeline core.

---
 rtl/alu_mc.sv | 157 +++++++++++++++
 tb/tb_alu_mc.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// Execution-stage ALU: single-cycle add/sub, iterative mul/div/rem, and a
// result-history buffer that feeds operand forwarding.
module alu_mc #(
  parameter int unsigned W         = 32,
  parameter int unsigned FWD_DEPTH = 2,
  parameter int unsigned SW        = $clog2(FWD_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  rs1,
  input  logic [W-1:0]  rs2,
  input  logic [SW-1:0] fwd_sel1,
  input  logic [SW-1:0] fwd_sel2,
  input  logic [6:0]    oper,
  output logic [W-1:0]  res_ALU,
  output logic          res_valid,
  output logic          flag_Z,
  output logic          flag_N,
  output logic          flag_DZ
);

  localparam int unsigned CW = $clog2(W + 1);

  typedef enum logic {IDLE, CALC} state_t;
  typedef enum logic [1:0] {K_MUL, K_DIV, K_REM} kind_t;

  state_t         state, state_d;
  kind_t          kind, kind_d;
  logic [CW-1:0]  cnt, cnt_d;
  logic [W-1:0]   acc, acc_d;   // product accumulator / partial remainder
  logic [W-1:0]   mb, mb_d;     // multiplier / dividend-then-quotient
  logic [W-1:0]   md, md_d;     // shifting multiplicand / divisor
  logic           dz, dz_d;
  logic           done;
  logic [W-1:0]   result;
  logic           res_dz;
  logic [W-1:0]   hist [FWD_DEPTH];
  logic [W-1:0]   op1, op2;
  logic [W-1:0]   mul_acc, rem_n, q_n;
  logic [W:0]     r_sh, diff;
  logic           qbit;

  assign in_ready = (state == IDLE);

  // Operand forwarding: select k picks the k-th most recent result
  always_comb begin
    op1 = rs1;
    op2 = rs2;
    for (int k = 1; k <= int'(FWD_DEPTH); k++) begin
      if (fwd_sel1 == SW'(k)) op1 = hist[k-1];
      if (fwd_sel2 == SW'(k)) op2 = hist[k-1];
    end
  end

  // One shift-add / restoring-divide step
  always_comb begin
    mul_acc = mb[0] ? acc + md : acc;
    r_sh    = {acc, mb[W-1]};
    diff    = r_sh - {1'b0, md};
    qbit    = ~diff[W];
    rem_n   = qbit ? diff[W-1:0] : r_sh[W-1:0];
    q_n     = {mb[W-2:0], qbit};
  end

  always_comb begin
    state_d = state;
    kind_d  = kind;
    cnt_d   = cnt;
    acc_d   = acc;
    mb_d    = mb;
    md_d    = md;
    dz_d    = dz;
    done    = 1'b0;
    result  = '0;
    res_dz  = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          case (oper)
            7'h01: begin done = 1'b1; result = op1 + op2; end
            7'h02: begin done = 1'b1; result = op1 - op2; end
            7'h03: begin
              state_d = CALC; kind_d = K_MUL; cnt_d = CW'(W);
              acc_d = '0; md_d = op1; mb_d = op2; dz_d = 1'b0;
            end
            7'h04, 7'h05: begin
              state_d = CALC; kind_d = (oper == 7'h04) ? K_DIV : K_REM;
              cnt_d = CW'(W);
              acc_d = '0; mb_d = op1; md_d = op2; dz_d = (op2 == '0);
            end
            default: begin done = 1'b1; result = '0; end
          endcase
        end
      end
      CALC: begin
        cnt_d = cnt - CW'(1);
        if (kind == K_MUL) begin
          acc_d = mul_acc;
          md_d  = {md[W-2:0], 1'b0};
          mb_d  = {1'b0, mb[W-1:1]};
        end else begin
          acc_d = rem_n;
          mb_d  = q_n;
        end
        if (cnt == CW'(1)) begin
          state_d = IDLE;
          done    = 1'b1;
          res_dz  = dz;
          case (kind)
            K_MUL:   result = mul_acc;
            K_DIV:   result = q_n;
            default: result = rem_n;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      kind      <= K_MUL;
      cnt       <= '0;
      acc       <= '0;
      mb        <= '0;
      md        <= '0;
      dz        <= 1'b0;
      res_ALU   <= '0;
      res_valid <= 1'b0;
      flag_Z    <= 1'b0;
      flag_N    <= 1'b0;
      flag_DZ   <= 1'b0;
      for (int k = 0; k < int'(FWD_DEPTH); k++) hist[k] <= '0;
    end else begin
      state     <= state_d;
      kind      <= kind_d;
      cnt       <= cnt_d;
      acc       <= acc_d;
      mb        <= mb_d;
      md        <= md_d;
      dz        <= dz_d;
      res_valid <= done;
      if (done) begin
        res_ALU <= result;
        flag_Z  <= (result == '0);
        flag_N  <= result[W-1];
        flag_DZ <= res_dz;
        hist[0] <= result;
        for (int k = 1; k < int'(FWD_DEPTH); k++) hist[k] <= hist[k-1];
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc with hand-computed expectations.
module tb_alu_mc;

  localparam int unsigned W = 32;
  localparam int unsigned SW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  rs1, rs2;
  logic [SW-1:0] fwd_sel1, fwd_sel2;
  logic [6:0]    oper;
  logic [W-1:0]  res_ALU;
  logic          res_valid, flag_Z, flag_N, flag_DZ;

  int n_cmp = 0;
  int n_bad = 0;

  alu_mc #(.W(W), .FWD_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
    .oper(oper), .res_ALU(res_ALU), .res_valid(res_valid),
    .flag_Z(flag_Z), .flag_N(flag_N), .flag_DZ(flag_DZ)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one request for a single edge; returns #1 after that edge
  task automatic drive(input logic [6:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [SW-1:0] s1, input logic [SW-1:0] s2);
    oper = op; rs1 = a; rs2 = b; fwd_sel1 = s1; fwd_sel2 = s2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; fwd_sel1 = '0; fwd_sel2 = '0;
  endtask

  task automatic single(input string tag, input logic [6:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [SW-1:0] s1, input logic [SW-1:0] s2,
                        input logic [W-1:0] exp);
    drive(op, a, b, s1, s2);
    check({tag, "_res"}, res_ALU, exp);
    check({tag, "_vld"}, W'(res_valid), W'(1));
    check({tag, "_z"}, W'(flag_Z), W'(exp == '0));
    check({tag, "_n"}, W'(flag_N), W'(exp[W-1]));
  endtask

  // Multi-cycle op; optionally pulses ignored requests while busy
  task automatic multi(input string tag, input logic [6:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp, input logic exp_dz,
                       input logic pulse);
    int n, busy_bad;
    n = 0; busy_bad = 0;
    drive(op, a, b, '0, '0);
    check({tag, "_rdy0"}, W'(in_ready), W'(0));
    while (n < 100) begin
      if (pulse && (n % 2 == 0)) begin
        in_valid = 1'b1; oper = 7'h01; rs1 = 9; rs2 = 0;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      n++;
      if (res_valid) break;
      if (in_ready) busy_bad++;
    end
    check({tag, "_lat"}, W'(n), W'(W));
    check({tag, "_busy"}, W'(busy_bad), W'(0));
    check({tag, "_res"}, res_ALU, exp);
    check({tag, "_dz"}, W'(flag_DZ), W'(exp_dz));
    check({tag, "_rdy1"}, W'(in_ready), W'(1));
    @(posedge clk); #1;
    check({tag, "_pulse"}, W'(res_valid), W'(0));
    check({tag, "_hold"}, res_ALU, exp);
  endtask

  initial begin
    int extra;
    rst_n = 1'b0; in_valid = 1'b0; rs1 = '0; rs2 = '0;
    fwd_sel1 = '0; fwd_sel2 = '0; oper = '0;
    #12;
    check("rst_res", res_ALU, '0);
    check("rst_vld", W'(res_valid), W'(0));
    check("rst_flags", W'({flag_Z, flag_N, flag_DZ}), W'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("rst_rdy", W'(in_ready), W'(1));

    // Basic add, one-cycle res_valid
    single("add", 7'h01, 3, 1, 0, 0, 4);
    @(posedge clk); #1;
    check("add_pulse", W'(res_valid), W'(0));
    check("add_hold", res_ALU, 4);

    // Back-to-back with forwarding of the previous result
    single("sub", 7'h02, 1, 2, 0, 0, 32'hFFFF_FFFF);
    single("fwd1", 7'h01, 0, 1, 1, 0, 0);
    single("illegal", 7'h7F, 5, 5, 0, 0, 0);

    multi("mul", 7'h03, 7, 6, 42, 1'b0, 1'b1);
    multi("mulbig", 7'h03, 32'h0001_0001, 32'h0001_0003, 32'h0004_0003, 1'b0, 1'b0);
    multi("div", 7'h04, 100, 7, 14, 1'b0, 1'b0);
    multi("rem", 7'h05, 100, 7, 2, 1'b0, 1'b0);
    multi("div0", 7'h04, 5, 0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    check("div0_n", W'(flag_N), W'(1));
    multi("rem0", 7'h05, 5, 0, 5, 1'b1, 1'b0);
    single("dzclr", 7'h01, 1, 1, 0, 0, 2);
    check("dzclr_dz", W'(flag_DZ), W'(0));

    // History depth and out-of-range select fallback
    single("h10", 7'h01, 10, 0, 0, 0, 10);
    single("h20", 7'h01, 20, 0, 0, 0, 20);
    single("fwd21", 7'h01, 0, 0, 2, 1, 30);
    single("fwd3", 7'h01, 5, 0, 3, 0, 5);
    single("neg", 7'h02, 0, 1, 0, 0, 32'hFFFF_FFFF);

    // Reset during the 10th CALC cycle of a divide
    drive(7'h04, 100, 7, 0, 0);
    repeat (9) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_res", res_ALU, '0);
    check("abort_vld", W'(res_valid), W'(0));
    check("abort_flags", W'({flag_Z, flag_N, flag_DZ}), W'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("abort_rdy", W'(in_ready), W'(1));
    extra = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (res_valid) extra++;
    end
    check("abort_novld", W'(extra), W'(0));
    single("abort_h1", 7'h01, 77, 0, 1, 0, 0);
    single("abort_h2", 7'h01, 0, 3, 2, 0, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
